// File: rtl/fifo_rd_burst_ctrl.sv
// Read-side burst client of the async FIFO (rclk domain).
// Pops LEN words and forwards them through a 2-entry skid buffer.
module fifo_rd_burst_ctrl #(
    parameter int DATA_SIZE   = 8,
    parameter int LEN_W       = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic                 rempty,
    input  logic [DATA_SIZE-1:0] rdata,
    output logic                 rinc,
    input  logic                 start,
    input  logic [LEN_W-1:0]     len,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic [LEN_W-1:0]     words_rd,
    output logic                 m_valid,
    output logic [DATA_SIZE-1:0] m_data,
    output logic                 m_last,
    input  logic                 m_ready
);

    localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BURST = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [LEN_W-1:0]     rem_q, rem_d;
    logic [LEN_W-1:0]     words_q, words_d;
    logic [TW-1:0]        tcnt_q, tcnt_d;
    logic                 to_q, to_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [DATA_SIZE-1:0] d0_q, d0_d, d1_q, d1_d;
    logic                 l0_q, l0_d, l1_q, l1_d;

    logic wait_c;
    logic fire;
    logic pop;
    logic last_in;

    assign rinc    = (state_q == S_BURST) && !rempty
                     && (rem_q != '0) && (cnt_q != 2'd2);
    assign wait_c  = (state_q == S_BURST) && rempty
                     && (rem_q != '0) && (cnt_q != 2'd2);
    assign fire    = wait_c && (tcnt_q == TW'(TIMEOUT_CYC));
    assign pop     = (cnt_q != 2'd0) && m_ready;
    assign last_in = (rem_q == LEN_W'(1));

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign timeout  = to_q;
    assign words_rd = words_q;
    assign m_valid  = (cnt_q != 2'd0);
    assign m_data   = d0_q;
    assign m_last   = (cnt_q != 2'd0) && l0_q;

    // Skid buffer: slot 0 is always the head; a push only happens below 2.
    always_comb begin
        cnt_d = cnt_q;
        d0_d  = d0_q;
        d1_d  = d1_q;
        l0_d  = l0_q;
        l1_d  = l1_q;
        if (rinc && pop) begin
            d0_d = rdata;
            l0_d = last_in;
        end else if (pop) begin
            d0_d  = d1_q;
            l0_d  = l1_q;
            cnt_d = cnt_q - 2'd1;
        end else if (rinc) begin
            if (cnt_q == 2'd0) begin
                d0_d = rdata;
                l0_d = last_in;
            end else begin
                d1_d = rdata;
                l1_d = last_in;
            end
            cnt_d = cnt_q + 2'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        words_d = words_q;
        tcnt_d  = tcnt_q;
        to_d    = to_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    words_d = '0;
                    tcnt_d  = '0;
                    to_d    = 1'b0;
                    if (len != '0) begin
                        rem_d   = len;
                        state_d = S_BURST;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_BURST: begin
                if (rinc) begin
                    rem_d   = rem_q - LEN_W'(1);
                    words_d = words_q + LEN_W'(1);
                    tcnt_d  = '0;
                    if (last_in) state_d = S_FLUSH;
                end else if (fire) begin
                    to_d    = 1'b1;
                    rem_d   = '0;
                    state_d = S_FLUSH;
                end else if (wait_c) begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            S_FLUSH: begin
                if (cnt_d == 2'd0) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            words_q <= '0;
            tcnt_q  <= '0;
            to_q    <= 1'b0;
            cnt_q   <= 2'd0;
            d0_q    <= '0;
            d1_q    <= '0;
            l0_q    <= 1'b0;
            l1_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            words_q <= words_d;
            tcnt_q  <= tcnt_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
            d0_q    <= d0_d;
            d1_q    <= d1_d;
            l0_q    <= l0_d;
            l1_q    <= l1_d;
        end
    end

endmodule

// File: tb/tb_fifo_rd_burst_ctrl.sv
// Directed bench for fifo_rd_burst_ctrl with a small FIFO model
// and a stream monitor.
module tb_fifo_rd_burst_ctrl;

    localparam int DW = 8;
    localparam int LW = 8;
    localparam int TO = 8;

    logic          rclk = 1'b0;
    logic          rrst;
    logic          rempty;
    logic [DW-1:0] rdata;
    logic          rinc;
    logic          start;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [LW-1:0] words_rd;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready;

    int total = 0;
    int bad   = 0;

    fifo_rd_burst_ctrl #(
        .DATA_SIZE(DW),
        .LEN_W(LW),
        .TIMEOUT_CYC(TO)
    ) dut (
        .rclk(rclk),
        .rrst(rrst),
        .rempty(rempty),
        .rdata(rdata),
        .rinc(rinc),
        .start(start),
        .len(len),
        .busy(busy),
        .done(done),
        .timeout(timeout),
        .words_rd(words_rd),
        .m_valid(m_valid),
        .m_data(m_data),
        .m_last(m_last),
        .m_ready(m_ready)
    );

    always #5 rclk = ~rclk;

    // FIFO model: ring of 16 words, popped on rinc edges
    logic [DW-1:0] mem [0:15];
    int rd_ptr = 0;
    int wr_ptr = 0;

    assign rempty = (rd_ptr == wr_ptr);
    assign rdata  = mem[rd_ptr[3:0]];

    always @(posedge rclk) begin
        if (rinc) rd_ptr <= rd_ptr + 1;
    end

    task automatic push(input logic [DW-1:0] v);
        mem[wr_ptr[3:0]] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    // Stream monitor, sampled 1 time unit before each rising edge
    int          rinc_cnt  = 0;
    int          stab_err  = 0;
    int          empty_err = 0;
    logic        prev_stall = 1'b0;
    logic [DW-1:0] prev_d = '0;
    logic        prev_l = 1'b0;
    logic [8:0]  rx [$];

    always begin
        @(negedge rclk);
        #4;
        if (rrst) begin
            prev_stall = 1'b0;
        end else begin
            if (rinc) rinc_cnt++;
            if (rinc && rempty) empty_err++;
            if (prev_stall && (!m_valid || m_data !== prev_d
                               || m_last !== prev_l))
                stab_err++;
            if (m_valid && m_ready) rx.push_back({m_last, m_data});
            prev_stall = m_valid && !m_ready;
            prev_d     = m_data;
            prev_l     = m_last;
        end
    end

    task automatic step();
        @(posedge rclk);
        @(negedge rclk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int maxc, output int n);
        n = 1;
        while (!done && n < maxc) begin
            step();
            #1;
            n++;
        end
    endtask

    initial begin
        logic [8:0] e1 [4];
        logic [8:0] e2 [4];
        logic [8:0] e6 [4];
        int base;
        int n;

        e1 = '{9'h011, 9'h012, 9'h013, 9'h114};
        e2 = '{9'h021, 9'h022, 9'h023, 9'h124};
        e6 = '{9'h035, 9'h036, 9'h037, 9'h138};

        rrst    = 1'b1;
        start   = 1'b0;
        len     = '0;
        m_ready = 1'b1;
        push(8'h11); push(8'h12); push(8'h13); push(8'h14);
        step();
        step();
        #1;
        chk("rst_rinc", 32'(rinc), 0);
        chk("rst_mvalid", 32'(m_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("rst_words", 32'(words_rd), 0);
        chk("rst_mlast", 32'(m_last), 0);
        chk("rst_mdata", 32'(m_data), 0);
        rrst = 1'b0;
        step();

        // 1: back-to-back burst of 4
        rx.delete();
        base  = rinc_cnt;
        start = 1'b1;
        len   = 8'd4;
        step();
        start = 1'b0;
        #1;
        chk("t1_c1_rinc", 32'(rinc), 1);
        chk("t1_c1_busy", 32'(busy), 1);
        chk("t1_c1_mvalid", 32'(m_valid), 0);
        step(); #1;
        chk("t1_c2_rinc", 32'(rinc), 1);
        chk("t1_c2_mdata", 32'(m_data), 32'h11);
        chk("t1_c2_words", 32'(words_rd), 1);
        step(); #1;
        chk("t1_c3_mdata", 32'(m_data), 32'h12);
        step(); #1;
        chk("t1_c4_rinc", 32'(rinc), 1);
        chk("t1_c4_mdata", 32'(m_data), 32'h13);
        chk("t1_c4_mlast", 32'(m_last), 0);
        step(); #1;
        chk("t1_c5_rinc", 32'(rinc), 0);
        chk("t1_c5_mdata", 32'(m_data), 32'h14);
        chk("t1_c5_mlast", 32'(m_last), 1);
        chk("t1_c5_done", 32'(done), 0);
        chk("t1_c5_words", 32'(words_rd), 4);
        step(); #1;
        chk("t1_c6_done", 32'(done), 1);
        chk("t1_c6_mvalid", 32'(m_valid), 0);
        step(); #1;
        chk("t1_c7_done", 32'(done), 0);
        chk("t1_c7_busy", 32'(busy), 0);
        chk("t1_rinc_cnt", 32'(rinc_cnt - base), 4);
        chk("t1_rx_size", 32'(rx.size()), 4);
        for (int i = 0; i < 4; i++) chk("t1_rx", 32'(rx[i]), 32'(e1[i]));

        // 2: backpressure for 5 cycles mid-burst
        push(8'h21); push(8'h22); push(8'h23); push(8'h24);
        rx.delete();
        base  = rinc_cnt;
        start = 1'b1;
        len   = 8'd4;
        step();
        start = 1'b0;
        #1;
        chk("t2_c1_rinc", 32'(rinc), 1);
        step();
        m_ready = 1'b0;
        #1;
        chk("t2_c2_rinc", 32'(rinc), 1);
        chk("t2_c2_mdata", 32'(m_data), 32'h21);
        for (int c = 3; c <= 6; c++) begin
            step(); #1;
            chk("t2_stall_rinc", 32'(rinc), 0);
            chk("t2_stall_mdata", 32'(m_data), 32'h21);
            chk("t2_stall_mvalid", 32'(m_valid), 1);
        end
        step();
        m_ready = 1'b1;
        #1;
        chk("t2_c7_rinc", 32'(rinc), 0);
        chk("t2_c7_mdata", 32'(m_data), 32'h21);
        step(); #1;
        chk("t2_c8_rinc", 32'(rinc), 1);
        chk("t2_c8_mdata", 32'(m_data), 32'h22);
        step(); #1;
        chk("t2_c9_mdata", 32'(m_data), 32'h23);
        step(); #1;
        chk("t2_c10_mdata", 32'(m_data), 32'h24);
        chk("t2_c10_mlast", 32'(m_last), 1);
        step(); #1;
        chk("t2_c11_done", 32'(done), 1);
        chk("t2_c11_words", 32'(words_rd), 4);
        chk("t2_rinc_cnt", 32'(rinc_cnt - base), 4);
        chk("t2_rx_size", 32'(rx.size()), 4);
        for (int i = 0; i < 4; i++) chk("t2_rx", 32'(rx[i]), 32'(e2[i]));
        chk("t2_stable", 32'(stab_err), 0);
        step();

        // 3: FIFO stays empty, burst times out
        base  = rinc_cnt;
        start = 1'b1;
        len   = 8'd3;
        step();
        start = 1'b0;
        #1;
        wait_done(30, n);
        chk("t3_done_seen", 32'(done), 1);
        chk("t3_done_cycle", 32'(n), 11);
        chk("t3_timeout", 32'(timeout), 1);
        chk("t3_words", 32'(words_rd), 0);
        chk("t3_no_rinc", 32'(rinc_cnt - base), 0);
        step(); #1;
        chk("t3_sticky", 32'(timeout), 1);
        chk("t3_busy", 32'(busy), 0);

        // 4: zero-length burst
        start = 1'b1;
        len   = 8'd0;
        step();
        start = 1'b0;
        #1;
        chk("t4_done", 32'(done), 1);
        chk("t4_rinc", 32'(rinc), 0);
        chk("t4_timeout", 32'(timeout), 0);
        chk("t4_words", 32'(words_rd), 0);
        step(); #1;
        chk("t4_done_drop", 32'(done), 0);
        chk("t4_busy", 32'(busy), 0);

        // 5: reset with two words buffered
        push(8'h31); push(8'h32); push(8'h33);
        push(8'h34); push(8'h35); push(8'h36);
        m_ready = 1'b0;
        start   = 1'b1;
        len     = 8'd6;
        step();
        start = 1'b0;
        #1;
        chk("t5_c1_rinc", 32'(rinc), 1);
        step(); #1;
        step(); #1;
        chk("t5_c3_rinc", 32'(rinc), 0);
        chk("t5_c3_mvalid", 32'(m_valid), 1);
        chk("t5_c3_words", 32'(words_rd), 2);
        rrst = 1'b1;
        #1;
        chk("t5_rst_mvalid", 32'(m_valid), 0);
        chk("t5_rst_rinc", 32'(rinc), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_words", 32'(words_rd), 0);
        step();
        rrst    = 1'b0;
        m_ready = 1'b1;
        rx.delete();
        start = 1'b1;
        len   = 8'd2;
        step();
        start = 1'b0;
        #1;
        wait_done(20, n);
        chk("t5_done_seen", 32'(done), 1);
        chk("t5_words", 32'(words_rd), 2);
        chk("t5_timeout", 32'(timeout), 0);
        chk("t5_rx_size", 32'(rx.size()), 2);
        chk("t5_rx0", 32'(rx[0]), 32'h033);
        chk("t5_rx1", 32'(rx[1]), 32'h134);
        step();

        // 6: start while busy is ignored
        push(8'h37); push(8'h38);
        rx.delete();
        base  = rinc_cnt;
        start = 1'b1;
        len   = 8'd4;
        step();
        start = 1'b0;
        #1;
        chk("t6_c1_rinc", 32'(rinc), 1);
        step();
        start = 1'b1;
        len   = 8'd9;
        #1;
        chk("t6_c2_busy", 32'(busy), 1);
        step();
        start = 1'b0;
        len   = '0;
        #1;
        wait_done(20, n);
        chk("t6_done_seen", 32'(done), 1);
        chk("t6_words", 32'(words_rd), 4);
        chk("t6_rx_size", 32'(rx.size()), 4);
        for (int i = 0; i < 4; i++) chk("t6_rx", 32'(rx[i]), 32'(e6[i]));
        step(); #1;
        chk("t6_busy", 32'(busy), 0);
        chk("t6_rinc_cnt", 32'(rinc_cnt - base), 4);
        chk("t6_fifo_drained", 32'(wr_ptr - rd_ptr), 0);

        chk("never_rd_empty", 32'(empty_err), 0);
        chk("stream_stable", 32'(stab_err), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
